// File: rtl/ahb_rr_arbiter_slave.sv
// ahb_rr_arbiter_slave
//    Round-robin, burst-aware arbiter guarding one AHB slave port. A master
//    that wins the slave keeps it until its last beat is accepted, it drops
//    its request, or it has been accepted MAX_BEATS beats without a last
//    beat (forced release, flagged by a one-cycle timeout pulse).
//
// Ports
//    hclk      : clock, all state changes on the rising edge
//    hreset_n  : asynchronous active-low reset
//    hreq      : per-master request (level)
//    hlast     : per-master last-beat flag, qualified by the beat
//    hwait     : slave stall, high means the current beat is not accepted
//    hgrant    : one-hot beat grant (owner gated by hwait)
//    hsel      : slave selected (any owner present)
//    hmaster   : index of the current owner, 0 when idle
//    timeout   : one-cycle pulse in the first cycle after a forced release

module ahb_rr_arbiter_slave #(
   parameter int MASTER_NUM = 4,
   parameter int MAX_BEATS  = 16,
   parameter int MID_W      = $clog2(MASTER_NUM)
) (
   input  logic                  hclk,
   input  logic                  hreset_n,
   input  logic [MASTER_NUM-1:0] hreq,
   input  logic [MASTER_NUM-1:0] hlast,
   input  logic                  hwait,
   output logic [MASTER_NUM-1:0] hgrant,
   output logic                  hsel,
   output logic [MID_W-1:0]      hmaster,
   output logic                  timeout
);

   localparam int                BEAT_W     = $clog2(MAX_BEATS + 1);
   localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_BEATS);
   localparam logic [MID_W-1:0]  PTR_RESET  = MID_W'(MASTER_NUM - 1);

   logic [MASTER_NUM-1:0] owner_q, owner_d;
   logic [MID_W-1:0]      ptr_q, ptr_d;
   logic [BEAT_W-1:0]     beats_q, beats_d;
   logic                  timeout_q, timeout_d;

   logic [MID_W-1:0]      owner_idx;
   logic [MID_W-1:0]      search_base;
   logic [MID_W-1:0]      winner_idx;
   logic                  winner_vld;
   logic [MASTER_NUM-1:0] winner_onehot;
   int                    best_dist;
   int                    cand_dist;

   logic owner_last;
   logic owner_req;
   logic count_hit;

   assign hsel       = |owner_q;
   assign hgrant     = owner_q & {MASTER_NUM{~hwait}};
   assign hmaster    = owner_idx;
   assign timeout    = timeout_q;

   // The owner vector is one-hot, so masking avoids indexing by owner_idx.
   assign owner_last = |(owner_q & hlast);
   assign owner_req  = |(owner_q & hreq);
   assign count_hit  = (beats_q + BEAT_W'(1)) == BEAT_LIMIT;

   // One-hot to index; all-zero owner encodes as 0.
   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (owner_q[i]) begin
            owner_idx = MID_W'(i);
         end
      end
   end

   // The search starts just after the releasing owner when busy, or after
   // the last winner when idle; the base itself is reached last.
   assign search_base = hsel ? owner_idx : ptr_q;

   // Each requester's distance from base+1 (mod MASTER_NUM) is its rotated
   // position; the smallest distance is the round-robin winner.
   always_comb begin
      winner_vld = 1'b0;
      winner_idx = '0;
      best_dist  = MASTER_NUM;
      cand_dist  = 0;
      for (int j = 0; j < MASTER_NUM; j++) begin
         if (hreq[j]) begin
            cand_dist = (j + MASTER_NUM - int'(search_base) - 1) % MASTER_NUM;
            if (cand_dist < best_dist) begin
               best_dist  = cand_dist;
               winner_vld = 1'b1;
               winner_idx = MID_W'(j);
            end
         end
      end
   end

   assign winner_onehot = winner_vld ? (MASTER_NUM'(1) << winner_idx) : '0;

   // Tenure control. A stalled beat (hwait high) freezes everything, so a
   // beat in flight is never abandoned and non-owners can never preempt.
   // timeout only flags the beat-count release while the owner still wants
   // the slave; a last beat or a dropped request is a voluntary release.
   always_comb begin
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      beats_d   = beats_q;
      timeout_d = 1'b0;
      if (!hsel) begin
         if (winner_vld) begin
            owner_d = winner_onehot;
            ptr_d   = winner_idx;
            beats_d = '0;
         end
      end else if (!hwait) begin
         if (owner_last || !owner_req || count_hit) begin
            timeout_d = count_hit && !owner_last && owner_req;
            beats_d   = '0;
            if (winner_vld) begin
               owner_d = winner_onehot;
               ptr_d   = winner_idx;
            end else begin
               owner_d = '0;
            end
         end else if (beats_q != BEAT_LIMIT) begin
            beats_d = beats_q + BEAT_W'(1);
         end
      end
   end

   // ptr resets to the top master so master 0 is first in line.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         owner_q   <= '0;
         ptr_q     <= PTR_RESET;
         beats_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         beats_q   <= beats_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_ahb_rr_arbiter_slave.sv
// tb_ahb_rr_arbiter_slave
//    Directed scenarios with constant expectations, followed by randomized
//    traffic compared against a tenure-level reference model.

module tb_ahb_rr_arbiter_slave;

   localparam int N  = 4;
   localparam int MB = 4;
   localparam int MW = 2;

   logic          hclk = 1'b0;
   logic          hreset_n;
   logic [N-1:0]  hreq;
   logic [N-1:0]  hlast;
   logic          hwait;
   logic [N-1:0]  hgrant;
   logic          hsel;
   logic [MW-1:0] hmaster;
   logic          timeout;

   int errors = 0;
   int checks = 0;

   // Reference model: owner as an integer (-1 = nobody), last winner,
   // accepted-beat count of the current tenure.
   int   m_owner, m_last, m_beats;
   logic m_timeout;
   int   n_owner, n_last, n_beats;
   logic n_timeout;

   always #5 hclk = ~hclk;

   ahb_rr_arbiter_slave #(.MASTER_NUM(N), .MAX_BEATS(MB), .MID_W(MW)) dut (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .hreq     (hreq),
      .hlast    (hlast),
      .hwait    (hwait),
      .hgrant   (hgrant),
      .hsel     (hsel),
      .hmaster  (hmaster),
      .timeout  (timeout)
   );

   // First requester found walking upward from the master after 'from'.
   function automatic int pick(input logic [N-1:0] req, input int from);
      int c;
      for (int k = 1; k <= N; k++) begin
         c = (from + k) % N;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   // Next model state from the current inputs.
   always_comb begin
      n_owner   = m_owner;
      n_last    = m_last;
      n_beats   = m_beats;
      n_timeout = 1'b0;
      if (m_owner < 0) begin
         n_owner = pick(hreq, m_last);
         if (n_owner >= 0) begin
            n_last  = n_owner;
            n_beats = 0;
         end
      end else if (!hwait) begin
         if (hlast[m_owner] || !hreq[m_owner] || (m_beats + 1 == MB)) begin
            n_timeout = !hlast[m_owner] && hreq[m_owner];
            n_owner   = pick(hreq, m_owner);
            if (n_owner >= 0) n_last = n_owner;
            n_beats = 0;
         end else begin
            n_beats = m_beats + 1;
         end
      end
   end

   // Model state register, reset alongside the DUT.
   always @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         m_owner   <= -1;
         m_last    <= N - 1;
         m_beats   <= 0;
         m_timeout <= 1'b0;
      end else begin
         m_owner   <= n_owner;
         m_last    <= n_last;
         m_beats   <= n_beats;
         m_timeout <= n_timeout;
      end
   end

   // Short reset pulse placed between clock edges, inputs quiet.
   task automatic do_reset();
      @(posedge hclk);
      #1;
      hreq     = '0;
      hlast    = '0;
      hwait    = 1'b0;
      hreset_n = 1'b0;
      #2;
      hreset_n = 1'b1;
   endtask

   task automatic test_reset();
      hreq     = '0;
      hlast    = '0;
      hwait    = 1'b0;
      hreset_n = 1'b0;
      #12;
      checks++; if (hgrant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_hgrant: got %b want 0000", hgrant); end
      checks++; if (hsel !== 1'b0) begin errors++; $display("[TB] FAIL reset_hsel: got %b want 0", hsel); end
      checks++; if (hmaster !== 2'd0) begin errors++; $display("[TB] FAIL reset_hmaster: got %0d want 0", hmaster); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout); end
      @(negedge hclk);
      hreset_n = 1'b1;
      @(posedge hclk);
      #1;
      checks++; if (hsel !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_hsel: got %b want 0", hsel); end
   endtask

   task automatic test_single();
      do_reset();
      hreq = 4'b0100;
      @(posedge hclk); #1;
      checks++; if (hgrant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant_c1: got %b want 0100", hgrant); end
      checks++; if (hmaster !== 2'd2) begin errors++; $display("[TB] FAIL single_hmaster: got %0d want 2", hmaster); end
      @(posedge hclk); #1;
      checks++; if (hgrant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant_c2: got %b want 0100", hgrant); end
      @(posedge hclk); #1;
      hlast = 4'b0100;
      hreq  = 4'b0000;
      #1;
      checks++; if (hgrant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant_c3: got %b want 0100", hgrant); end
      @(posedge hclk); #1;
      hlast = 4'b0000;
      #1;
      checks++; if (hsel !== 1'b0) begin errors++; $display("[TB] FAIL single_release_hsel: got %b want 0", hsel); end
      checks++; if (hmaster !== 2'd0) begin errors++; $display("[TB] FAIL single_release_hmaster: got %0d want 0", hmaster); end
   endtask

   task automatic test_fairness();
      int expOrder [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] one = 4'b0001;
      do_reset();
      hreq  = 4'b1111;
      hlast = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(posedge hclk); #2;
         checks++; if (hmaster !== MW'(expOrder[i])) begin errors++; $display("[TB] FAIL fair_order[%0d]: got %0d want %0d", i, hmaster, expOrder[i]); end
         checks++; if (hgrant !== (one << expOrder[i])) begin errors++; $display("[TB] FAIL fair_grant[%0d]: got %b want %b", i, hgrant, one << expOrder[i]); end
      end
      hreq  = '0;
      hlast = '0;
   endtask

   task automatic test_stall();
      do_reset();
      hreq = 4'b0010;
      @(posedge hclk); #1;
      hreq  = 4'b0110;
      hlast = 4'b0010;
      hwait = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (hgrant !== 4'b0000) begin errors++; $display("[TB] FAIL stall_grant[%0d]: got %b want 0000", i, hgrant); end
         checks++; if (hsel !== 1'b1) begin errors++; $display("[TB] FAIL stall_hsel[%0d]: got %b want 1", i, hsel); end
         checks++; if (hmaster !== 2'd1) begin errors++; $display("[TB] FAIL stall_owner[%0d]: got %0d want 1", i, hmaster); end
         @(posedge hclk); #2;
      end
      hwait = 1'b0;
      #1;
      checks++; if (hgrant !== 4'b0010) begin errors++; $display("[TB] FAIL stall_release_grant: got %b want 0010", hgrant); end
      @(posedge hclk); #1;
      hlast = 4'b0000;
      hreq  = 4'b0000;
      #1;
      checks++; if (hmaster !== 2'd2) begin errors++; $display("[TB] FAIL stall_handover: got %0d want 2", hmaster); end
   endtask

   task automatic test_timeout();
      do_reset();
      hreq = 4'b0001;
      @(posedge hclk); #1;
      hreq = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (hmaster !== 2'd0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL tmo_stream[%0d]: got owner %0d timeout %b want owner 0 timeout 0", i, hmaster, timeout); end
         @(posedge hclk); #1;
      end
      hreq  = 4'b1000;
      hlast = 4'b1000;
      #1;
      checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL tmo_pulse: got %b want 1", timeout); end
      checks++; if (hgrant !== 4'b1000) begin errors++; $display("[TB] FAIL tmo_new_owner: got %b want 1000", hgrant); end
      @(posedge hclk); #1;
      hreq  = '0;
      hlast = '0;
      #1;
      checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL tmo_width: got %b want 0", timeout); end
   endtask

   task automatic test_drop();
      do_reset();
      hreq = 4'b0100;
      @(posedge hclk); #1;
      @(posedge hclk); #1;
      hreq = 4'b0000;
      @(posedge hclk); #1;
      #1;
      checks++; if (hsel !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle: got %b want 0", hsel); end
      checks++; if (hmaster !== 2'd0) begin errors++; $display("[TB] FAIL drop_hmaster: got %0d want 0", hmaster); end
      hreq = 4'b0101;
      @(posedge hclk); #2;
      checks++; if (hgrant !== 4'b0001) begin errors++; $display("[TB] FAIL drop_next_winner: got %b want 0001", hgrant); end
      hreq = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      hreq = 4'b1000;
      @(posedge hclk); #1;
      checks++; if (hmaster !== 2'd3) begin errors++; $display("[TB] FAIL rstmid_setup: got %0d want 3", hmaster); end
      @(posedge hclk); #3;
      hreset_n = 1'b0;
      #1;
      checks++; if (hgrant !== 4'b0000 || hsel !== 1'b0 || hmaster !== 2'd0 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_async: got grant %b sel %b master %0d timeout %b want all zero", hgrant, hsel, hmaster, timeout);
      end
      #1;
      hreset_n = 1'b1;
      hreq     = 4'b1111;
      @(posedge hclk); #2;
      checks++; if (hmaster !== 2'd0) begin errors++; $display("[TB] FAIL rstmid_restart: got %0d want 0", hmaster); end
      hreq = '0;
   endtask

   task automatic test_random();
      logic [N-1:0] one = 4'b0001;
      logic [N-1:0] expGrant;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge hclk); #1;
         for (int b = 0; b < N; b++) begin
            hreq[b]  = ($urandom_range(0, 9) < 8);
            hlast[b] = ($urandom_range(0, 3) == 0);
         end
         hwait = ($urandom_range(0, 3) == 0);
         #1;
         expGrant = (m_owner >= 0 && !hwait) ? (one << m_owner) : 4'b0000;
         checks++; if (hgrant !== expGrant) begin errors++; $display("[TB] FAIL rand_hgrant @%0d: got %b want %b", cyc, hgrant, expGrant); end
         checks++; if (hsel !== (m_owner >= 0)) begin errors++; $display("[TB] FAIL rand_hsel @%0d: got %b want %b", cyc, hsel, m_owner >= 0); end
         checks++; if (hmaster !== MW'(m_owner < 0 ? 0 : m_owner)) begin errors++; $display("[TB] FAIL rand_hmaster @%0d: got %0d want %0d", cyc, hmaster, m_owner < 0 ? 0 : m_owner); end
         checks++; if (timeout !== m_timeout) begin errors++; $display("[TB] FAIL rand_timeout @%0d: got %b want %b", cyc, timeout, m_timeout); end
      end
      hreq  = '0;
      hlast = '0;
      hwait = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_stall();
      test_timeout();
      test_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ahb_rr_arbiter_slave.md
# ahb_rr_arbiter_slave

Round-robin, burst-aware arbiter for one AHB slave port in the generated interconnect. It shares the slave between `MASTER_NUM` requesting masters. An owning master keeps the slave until its last beat is accepted, it drops its request, or a beat-count timeout fires. It drops in beside the fixed-priority per-slave arbiters wherever fairness is required.

## Interface
Parameters:
- `MASTER_NUM`, 4: number of requesting masters (2..16).
- `MAX_BEATS`, 16: accepted beats allowed per tenure before forced release (1..256).
- `MID_W`, `$clog2(MASTER_NUM)`: width of `hmaster`.

Ports:
- `hclk`, in, 1: clock; all state changes on its rising edge.
- `hreset_n`, in, 1: reset, asynchronous, active-low.
- `hreq`, in, `MASTER_NUM`: per-master request, level.
- `hlast`, in, `MASTER_NUM`: per-master last-beat flag, valid with the beat.
- `hwait`, in, 1: slave stall; high means the current beat is not accepted.
- `hgrant`, out, `MASTER_NUM`: one-hot beat grant, equal to `owner & ~hwait`.
- `hsel`, out, 1: slave selected, equal to `|owner`.
- `hmaster`, out, `MID_W`: index of the current owner; 0 when there is no owner.
- `timeout`, out, 1: one-cycle pulse on a forced release.

## Operation
- State is IDLE (owner = 0) or BUSY (owner one-hot). Registers: `owner[MASTER_NUM]`, `ptr[MID_W]` (last winner), `beats` (`$clog2(MAX_BEATS+1)` bits).
- Selection: combinational search over `hreq` starting at `ptr+1` modulo `MASTER_NUM`, wrapping. The first set bit wins, so the last winner has lowest priority.
- IDLE:
  - If any `hreq` is set, owner <= winner, ptr <= winner index, beats <= 0, and the state moves to BUSY.
  - Otherwise the state stays IDLE.
- BUSY: a beat is accepted when `~hwait`. Release occurs on any of:
  - (a) accepted beat with `hlast[owner]` = 1;
  - (b) `hreq[owner]` = 0 while `~hwait`; a stalled beat is never abandoned;
  - (c) accepted beat that makes `beats+1 == MAX_BEATS` without `hlast`. `timeout` pulses in the next cycle.
- On release:
  - Winner selection uses `ptr` = the releasing owner.
  - If any other master requests, it becomes owner the next cycle, so handover costs no idle cycle.
  - If only the releasing owner requests, it is re-granted.
  - If none request, the state goes to IDLE.
- Otherwise `beats` increments on each accepted beat. `beats` saturates and never wraps.
- If `hwait` is high, no release occurs and nothing changes except holding.
- `hreq` of non-owners is ignored during BUSY. Requests changing mid-tenure never preempt the owner.

## Timing
- Reset (asynchronous assert, synchronous release): owner = 0, `ptr = MASTER_NUM-1` so master 0 wins first, beats = 0. Resulting outputs: `hgrant = 0`, `hsel = 0`, `hmaster = 0`, `timeout = 0`.
- Request latency: `hreq` sampled high at edge N in IDLE gives `hsel`/`hgrant` high from cycle N+1.
- Handover: a last beat accepted in cycle N gives the new owner's `hgrant` in cycle N+1.
- `hgrant` falls combinationally with `hwait` in the same cycle. `hsel` stays high through stalls.
- `timeout` is registered and lasts exactly 1 cycle, aligned with the first cycle after release.
- Reset asserted mid-tenure: all outputs go to their reset values immediately. The round-robin pointer restarts at master 0.

## Test plan
- Reset and single request: release reset, then `hreq = 4'b0100` with a 3-beat burst and no `hwait`, `hlast` on beat 3. Required: `hgrant = 0100` from cycle 1, `hmaster = 2`, released after beat 3, IDLE with `hsel = 0` next cycle.
- Fairness: `hreq = 4'b1111` held, each tenure one beat with `hlast`. Required: grant order 0,1,2,3,0 on consecutive cycles with no idle gap.
- Stall hold: owner 1 on its last beat with `hwait = 1` for 3 cycles while master 2 requests. Required: `hgrant = 0` and `hsel = 1` for those 3 cycles, owner unchanged; master 2 granted the cycle after `hwait` drops.
- Timeout: `MAX_BEATS = 4`, owner 0 streams beats with `hlast = 0` and master 3 requesting. Required: release after 4th accepted beat, `timeout` = 1 for exactly 1 cycle, master 3 owns the next cycle.
- Request drop: owner 2 deasserts `hreq` mid-burst with `hwait = 0` and no other requesters. Required: IDLE next cycle, `hmaster = 0`, `ptr = 2`, so a later `hreq = 4'b0101` is granted to master 0.
- Reset mid-operation: assert `hreset_n` low while owner 3 is BUSY. Required: `hgrant`, `hsel`, `hmaster` = 0 asynchronously; after release, `hreq = 1111` grants master 0 first.
